gshare_pht: RTL and testbench

Global-history branch direction predictor for the RV32I pipeline: a pattern history table (PHT) of 2-bit saturating counters indexed by fetch PC XOR a global history shift register (GHSR). It sits upstream of the branch control unit. In Fetch it supplies `o_predict_PHT`. In Execute it consumes the control unit's `o_update_PHT_GHSR` / `o_actual_branch` to train the counter and shift the history. An initialisation sweep writes every entry after reset, so the table can map to non-resettable storage.

---
 rtl/bp_pkg.sv | 19 +
 rtl/pht_sat_ctr.sv | 21 ++
 rtl/gshare_pht.sv | 104 ++++++++++
 tb/tb_gshare_pht.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor slice.
// Counter encodings, FSM states and default history width.
package bp_pkg;

   localparam int GHR_W_DEF = 8;

   typedef logic [1:0] ctr_t;

   localparam ctr_t SNT = 2'd0;
   localparam ctr_t WNT = 2'd1;
   localparam ctr_t WT  = 2'd2;
   localparam ctr_t ST  = 2'd3;

   typedef enum logic {
      INIT,
      RUN
   } bp_state_e;

endpackage

// File: rtl/pht_sat_ctr.sv
// 2-bit saturating counter next-value function.
// Taken counts up to ST, not-taken counts down to SNT.
module pht_sat_ctr
   import bp_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   // Step toward the resolved direction, holding at either end.
   always_comb begin
      ctr_o = ctr_i;
      if (taken_i && (ctr_i != ST)) begin
         ctr_o = ctr_i + 2'd1;
      end else if (!taken_i && (ctr_i != SNT)) begin
         ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/gshare_pht.sv
// Gshare direction predictor: PHT indexed by PC ^ GHSR.
// A post-reset sweep initialises the non-resettable table.
module gshare_pht
   import bp_pkg::*;
#(
   parameter int         GHR_W   = GHR_W_DEF,
   parameter logic [1:0] RST_CNT = WNT
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [31:0]      i_pc_F,
   output logic             o_predict_PHT,
   output logic [GHR_W-1:0] o_index_F,
   input  logic             i_update_PHT_GHSR,
   input  logic             i_actual_branch,
   input  logic [GHR_W-1:0] i_index_E,
   output logic             o_init_busy,
   output logic [GHR_W-1:0] o_ghsr
);

   localparam int DEPTH = 1 << GHR_W;
   localparam logic [GHR_W-1:0] LAST = '1;
   localparam logic [GHR_W-1:0] ONE  = {{(GHR_W-1){1'b0}}, 1'b1};

   bp_state_e        state_q, state_d;
   logic [GHR_W-1:0] ptr_q, ptr_d;
   logic [GHR_W-1:0] ghsr_q, ghsr_d;
   logic [1:0]       pht_q [DEPTH];

   logic             run;
   logic             we;
   logic [GHR_W-1:0] waddr;
   logic [1:0]       wdata;
   logic [1:0]       ctr_next;
   logic [1:0]       rd_ctr;
   logic             unused_pc;

   assign run = (state_q == RUN);

   // Control and history registers; table itself is not reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= INIT;
         ptr_q   <= '0;
         ghsr_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ghsr_q  <= ghsr_d;
      end
   end

   // Sweep pointer in INIT, committed history shift in RUN.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ghsr_d  = ghsr_q;
      unique case (state_q)
         INIT: begin
            ptr_d = ptr_q + ONE;
            if (ptr_q == LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (i_update_PHT_GHSR) begin
               ghsr_d = {ghsr_q[GHR_W-2:0], i_actual_branch};
            end
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   pht_sat_ctr u_ctr (
      .ctr_i   (pht_q[i_index_E]),
      .taken_i (i_actual_branch),
      .ctr_o   (ctr_next)
   );

   // Single write port shared by the sweep and Execute training.
   always_comb begin
      we    = !run || i_update_PHT_GHSR;
      waddr = run ? i_index_E : ptr_q;
      wdata = run ? ctr_next : RST_CNT;
   end

   // Table storage; reads below see the pre-edge value (no bypass).
   always_ff @(posedge i_clk) begin
      if (we) begin
         pht_q[waddr] <= wdata;
      end
   end

   assign o_index_F     = i_pc_F[GHR_W+1:2] ^ ghsr_q;
   assign rd_ctr        = pht_q[o_index_F];
   assign o_predict_PHT = run && rd_ctr[1];
   assign o_init_busy   = !run;
   assign o_ghsr        = ghsr_q;

   assign unused_pc = ^{i_pc_F[31:GHR_W+2], i_pc_F[1:0]};

endmodule

// File: tb/tb_gshare_pht.sv
// Scoreboard bench for gshare_pht against a table/integer model.
// Stimulus pushes expectations; a monitor pops and compares.
module tb_gshare_pht;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_F = '0;
   logic        upd = 1'b0;
   logic        act = 1'b0;
   logic [7:0]  idxE = '0;
   logic        pred;
   logic [7:0]  idxF;
   logic        busy;
   logic [7:0]  ghsr;

   gshare_pht #(.GHR_W(8), .RST_CNT(2'b01)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_pc_F            (pc_F),
      .o_predict_PHT     (pred),
      .o_index_F         (idxF),
      .i_update_PHT_GHSR (upd),
      .i_actual_branch   (act),
      .i_index_E         (idxE),
      .o_init_busy       (busy),
      .o_ghsr            (ghsr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       pred;
      logic [7:0] idx;
      logic       busy;
      logic [7:0] ghsr;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   int   tbl [256];
   int   ghist;
   int   init_left;

   function automatic void check(input string nm, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
      end
   endfunction

   function automatic void model_reset();
      ghist     = 0;
      init_left = 256;
   endfunction

   function automatic logic [31:0] pc_for(input int ix);
      logic [31:0] hi;
      logic [31:0] lo;
      int          v;
      hi = $urandom & 32'hFFFF_FC00;
      lo = $urandom & 32'h3;
      v  = (ix ^ ghist) & 255;
      return hi | (32'(v) << 2) | lo;
   endfunction

   task automatic cycle(input logic r, input logic [31:0] p, input logic u,
                        input logic a, input logic [7:0] ie);
      exp_t e;
      int   ix;
      int   c;
      @(negedge clk);
      rst_n = r;
      pc_F  = p;
      upd   = u;
      act   = a;
      idxE  = ie;
      if (!r) model_reset();
      ix     = (int'(p[9:2]) ^ ghist) & 255;
      e.idx  = ix[7:0];
      e.busy = (init_left > 0);
      e.ghsr = ghist[7:0];
      e.pred = (init_left == 0) && (tbl[ix] >= 2);
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         if (init_left > 0) begin
            tbl[256 - init_left] = 1;
            init_left--;
         end else if (u) begin
            c = tbl[ie];
            if (a) c = (c == 3) ? 3 : c + 1;
            else   c = (c == 0) ? 0 : c - 1;
            tbl[ie] = c;
            ghist   = ((ghist << 1) | int'(a)) & 255;
         end
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         while (q.size() > 0) begin
            e = q.pop_front();
            check("predict", int'(pred), int'(e.pred));
            check("index_F", int'(idxF), int'(e.idx));
            check("init_busy", int'(busy), int'(e.busy));
            check("ghsr", int'(ghsr), int'(e.ghsr));
         end
      end
   end

   initial begin
      logic [7:0] pat;
      logic [7:0] ri;
      model_reset();
      for (int i = 0; i < 256; i++) tbl[i] = 0;
      for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, 1'b1, 1'b1, 8'h03);
      for (int i = 0; i < 260; i++)
         cycle(1'b1, $urandom, (i == 10), 1'b1, 8'h03);
      for (int i = 0; i < 256; i++)
         cycle(1'b1, pc_for(i), 1'b0, 1'b0, 8'h00);
      cycle(1'b1, $urandom, 1'b1, 1'b1, 8'h05);
      cycle(1'b1, $urandom, 1'b1, 1'b1, 8'h05);
      cycle(1'b1, 32'h0000_0018, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) cycle(1'b1, pc_for(8'h10), 1'b1, 1'b1, 8'h10);
      for (int i = 0; i < 6; i++) cycle(1'b1, pc_for(8'h10), 1'b1, 1'b0, 8'h10);
      cycle(1'b1, pc_for(8'h10), 1'b0, 1'b0, 8'h00);
      cycle(1'b1, $urandom, 1'b1, 1'b1, 8'h20);
      cycle(1'b1, pc_for(8'h20), 1'b1, 1'b0, 8'h20);
      cycle(1'b1, pc_for(8'h20), 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 1200; i++) begin
         ri = 8'($urandom_range(0, 15));
         cycle(1'b1, ($urandom_range(0, 1) == 1) ? pc_for(int'(ri)) : $urandom,
               1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)));
      end
      pat = 8'hA5;
      for (int i = 7; i >= 0; i--)
         cycle(1'b1, $urandom, 1'b1, pat[i], 8'($urandom));
      cycle(1'b1, $urandom, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, $urandom, 1'b1, 1'b1, 8'h00);
      for (int i = 0; i < 262; i++)
         cycle(1'b1, $urandom, 1'($urandom), 1'($urandom), 8'($urandom));
      for (int i = 0; i < 64; i++)
         cycle(1'b1, pc_for(i), 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
